// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gol_pkg
// Description : Shared types and helpers for the Game of Life key controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        CLEAR = 2'd3
    } gol_state_t;

    localparam int KEY_RUN   = 0;
    localparam int KEY_STEP  = 1;
    localparam int KEY_SPEED = 2;
    localparam int KEY_CLEAR = 3;

    localparam int FRAME_W = 5;

    // Frames per generation: 32, 16, 8 or 4.
    function automatic logic [FRAME_W:0] frame_period(input logic [1:0] spd);
        return 6'd32 >> spd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises and debounces one active-low key; pulses on press.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            // Any return to the accepted level restarts the qualification window.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
            r_stable_d <= r_stable;
            r_press    <= r_stable_d & ~r_stable;
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/gol_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gol_key_ctrl
// Description : Key front end and vsync-aligned generation pacer for Life.
// Revision    : 1.0 - initial release
// ============================================================================
module gol_key_ctrl
    import gol_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       vsync,
    output logic       gen_tick,
    output logic       clear_req,
    output logic       running,
    output logic [1:0] speed
);

    logic [3:0]         w_press;
    logic               r_vsync;
    logic               w_fs;
    gol_state_t         r_state;
    gol_state_t         w_state_nxt;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [FRAME_W-1:0] w_frame_cnt_nxt;
    logic [FRAME_W-1:0] w_frame_last;
    logic [1:0]         r_speed;
    logic [1:0]         w_speed_nxt;
    logic               r_gen_tick;
    logic               w_gen_nxt;
    logic               r_clear_req;
    logic               w_clr_nxt;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .key_n (key[i]),
                .press (w_press[i])
            );
        end
    endgenerate

    assign w_fs         = r_vsync & ~vsync;
    assign w_frame_last = FRAME_W'(frame_period(r_speed) - 6'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsync     <= 1'b1;
            r_state     <= PAUSE;
            r_frame_cnt <= '0;
            r_speed     <= 2'd0;
            r_gen_tick  <= 1'b0;
            r_clear_req <= 1'b0;
        end else begin
            r_vsync     <= vsync;
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_speed     <= w_speed_nxt;
            r_gen_tick  <= w_gen_nxt;
            r_clear_req <= w_clr_nxt;
        end
    end

    // A press always wins over a coincident frame start: the new state only
    // acts on the following frame.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_speed_nxt     = r_speed;
        w_gen_nxt       = 1'b0;
        w_clr_nxt       = 1'b0;
        case (r_state)
            PAUSE: begin
                if (w_press[KEY_CLEAR]) begin
                    w_state_nxt = CLEAR;
                end else if (w_press[KEY_RUN]) begin
                    w_state_nxt     = RUN;
                    w_frame_cnt_nxt = '0;
                end else if (w_press[KEY_STEP]) begin
                    w_state_nxt = STEP;
                end
            end
            RUN: begin
                if (w_press[KEY_CLEAR]) begin
                    w_state_nxt = CLEAR;
                end else if (w_press[KEY_RUN]) begin
                    w_state_nxt = PAUSE;
                end else if (w_fs) begin
                    if (r_frame_cnt == w_frame_last) begin
                        w_gen_nxt       = 1'b1;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            STEP: begin
                if (w_press[KEY_CLEAR]) begin
                    w_state_nxt = CLEAR;
                end else if (w_fs) begin
                    w_gen_nxt   = 1'b1;
                    w_state_nxt = PAUSE;
                end
            end
            CLEAR: begin
                if (w_fs) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = PAUSE;
                end
            end
            default: begin
                w_state_nxt = PAUSE;
            end
        endcase
        // CLEAR ignores every key, speed included.
        if (w_press[KEY_SPEED] && (r_state != CLEAR)) begin
            w_speed_nxt     = r_speed + 2'd1;
            w_frame_cnt_nxt = '0;
        end
    end

    assign gen_tick  = r_gen_tick;
    assign clear_req = r_clear_req;
    assign running   = (r_state == RUN);
    assign speed     = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_gol_key_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gol_key_ctrl
// Description : Directed self-checking bench for gol_key_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_key_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       vsync;
    logic       gen_tick;
    logic       clear_req;
    logic       running;
    logic [1:0] speed;

    always #5 clk = ~clk;

    gol_key_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .vsync     (vsync),
        .gen_tick  (gen_tick),
        .clear_req (clear_req),
        .running   (running),
        .speed     (speed)
    );

    int n_chk = 0;
    int n_pass = 0;
    int vcnt = 0;
    bit fs_pending = 1'b0;
    int fs_total = 0;
    int fs_at_gen = 0;
    int last_gap = 0;
    int n_gen = 0;
    int n_clr = 0;
    int n_both = 0;
    int n_misalign = 0;

    typedef struct {
        int idx;
        int low;
        int bounce;
        int exp_run;
        int exp_speed;
        int exp_gen;
        int exp_clr;
    } vec_t;

    vec_t vecs[10];

    // One clock: sample outputs at the falling edge, then advance vsync.
    task automatic tick();
        bit had_fs;
        @(negedge clk);
        had_fs = fs_pending;
        if (had_fs) fs_total++;
        if (gen_tick) begin
            n_gen++;
            last_gap  = fs_total - fs_at_gen;
            fs_at_gen = fs_total;
        end
        if (clear_req) n_clr++;
        if (gen_tick && clear_req) n_both++;
        if ((gen_tick || clear_req) && !had_fs) n_misalign++;
        vcnt++;
        vsync = ((vcnt % 20) != 0);
        fs_pending = !vsync;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic hold_key(input int idx, input int low, input int bounce, input int settle);
        for (int i = 0; i < low; i++) begin
            if (bounce == 0) key[idx] = 1'b0;
            else key[idx] = (((i / bounce) % 2) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        key[idx] = 1'b1;
        repeat (settle) tick();
    endtask

    task automatic wait_gen(input string name, input int budget);
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (!gen_tick && (i < budget));
        if (!gen_tick) check({name, " timeout"}, int'(gen_tick), 1);
    endtask

    task automatic align_vsync(input int phase);
        for (int i = 0; i < 40; i++) begin
            if ((vcnt % 20) == phase) break;
            tick();
        end
    endtask

    initial begin
        int g0, c0, lat, snap, fs_s;

        //            key len bnc run spd gen clr
        vecs[0] = '{0,  3, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 20, 2, 0, 0, 0, 0};
        vecs[2] = '{2, 10, 0, 0, 1, 0, 0};
        vecs[3] = '{2, 10, 0, 0, 2, 0, 0};
        vecs[4] = '{2, 10, 0, 0, 3, 0, 0};
        vecs[5] = '{2, 10, 0, 0, 0, 0, 0};
        vecs[6] = '{1, 10, 0, 0, 0, 1, 0};
        vecs[7] = '{3, 10, 0, 0, 0, 0, 1};
        vecs[8] = '{0, 10, 0, 1, 0, 0, 0};
        vecs[9] = '{0, 10, 0, 0, 0, 0, 0};

        reset = 1'b0;
        key   = 4'hF;
        vsync = 1'b1;
        repeat (3) tick();
        check("rst gen_tick", int'(gen_tick), 0);
        check("rst clear_req", int'(clear_req), 0);
        check("rst running", int'(running), 0);
        check("rst speed", int'(speed), 0);
        reset = 1'b1;
        repeat (5) tick();
        check("post-rst running", int'(running), 0);
        check("post-rst speed", int'(speed), 0);

        for (int r = 0; r < 10; r++) begin
            g0 = n_gen;
            c0 = n_clr;
            hold_key(vecs[r].idx, vecs[r].low, vecs[r].bounce, 50);
            check($sformatf("vec%0d running", r), int'(running), vecs[r].exp_run);
            check($sformatf("vec%0d speed", r), int'(speed), vecs[r].exp_speed);
            check($sformatf("vec%0d gen_tick count", r), n_gen - g0, vecs[r].exp_gen);
            check($sformatf("vec%0d clear_req count", r), n_clr - c0, vecs[r].exp_clr);
        end

        // Run latency and speed-0 pacing.
        key[0] = 1'b0;
        lat = -1;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (j == 10) key[0] = 1'b1;
            if (running && (lat < 0)) lat = j - 1;
        end
        check("run latency", lat, 7);
        wait_gen("spd0 first", 800);
        wait_gen("spd0 second", 800);
        check("spd0 frames per tick", last_gap, 32);

        // Speed 3: counter restarts on the last press.
        hold_key(2, 10, 0, 40);
        hold_key(2, 10, 0, 40);
        key[2] = 1'b0;
        snap = -1;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (j == 10) key[2] = 1'b1;
            if ((speed == 2'd3) && (snap < 0)) snap = fs_total;
        end
        check("spd3 reached", int'(speed), 3);
        wait_gen("spd3 first", 200);
        check("spd3 frames to first tick", fs_total - snap, 4);
        wait_gen("spd3 second", 200);
        check("spd3 frames per tick", last_gap, 4);
        hold_key(2, 10, 0, 40);
        hold_key(0, 10, 0, 40);
        check("paused again", int'(running), 0);

        // Step press consumed on the same edge as a frame start.
        align_vsync(13);
        key[1] = 1'b0;
        fs_s = fs_total;
        g0 = n_gen;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (j == 10) key[1] = 1'b1;
        end
        check("step+fs tick count", n_gen - g0, 1);
        check("step+fs frames to tick", fs_at_gen - fs_s, 2);
        check("step+fs running", int'(running), 0);

        // Clear and run together while running.
        hold_key(0, 10, 0, 40);
        check("run before clear", int'(running), 1);
        g0 = n_gen;
        c0 = n_clr;
        key[0] = 1'b0;
        key[3] = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (j == 10) begin
                key[0] = 1'b1;
                key[3] = 1'b1;
            end
        end
        check("clr+run clear_req count", n_clr - c0, 1);
        check("clr+run gen_tick count", n_gen - g0, 0);
        check("clr+run running", int'(running), 0);

        // Reset while a step is pending.
        align_vsync(14);
        key[1] = 1'b0;
        g0 = n_gen;
        c0 = n_clr;
        repeat (10) tick();
        key[1] = 1'b1;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (60) tick();
        check("rst-in-step gen_tick count", n_gen - g0, 0);
        check("rst-in-step clear_req count", n_clr - c0, 0);
        check("rst-in-step running", int'(running), 0);

        check("gen_tick with clear_req", n_both, 0);
        check("command not after fs", n_misalign, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
